// File: rtl/dx_interlock_latch_if.sv
// Bundle of the F/D-side inputs and D/X-side outputs of the decode/execute latch.
// The testbench or upstream stage drives through master; the latch itself uses slave.
interface dx_interlock_latch_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            fd_insn;
    logic [31:0]            fd_pc;
    logic                   flush;
    logic                   hold_ext;
    logic [31:0]            dx_insn_q;
    logic [31:0]            dx_pc_q;
    logic                   bubble_q;
    logic                   stall_fd;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output fd_insn, fd_pc, flush, hold_ext,
        input  dx_insn_q, dx_pc_q, bubble_q, stall_fd, stall_count
    );

    modport slave (
        input  fd_insn, fd_pc, flush, hold_ext,
        output dx_insn_q, dx_pc_q, bubble_q, stall_fd, stall_count
    );
endinterface

// File: rtl/dx_interlock_latch.sv
// D/X pipeline latch with load-use interlock: a bubble is injected when the F/D
// instruction reads the destination of an lw sitting in D/X; also honours hold and flush.
module dx_interlock_latch #(
    parameter logic [31:0] NOP_INSN    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input logic               clock,
    input logic               reset,
    dx_interlock_latch_if.slave bus
);
    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;

    typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_t;

    state_t                 state;
    logic [31:0]            dx_insn;
    logic [31:0]            dx_pc;
    logic                   bubble;
    logic [STALL_CNT_W-1:0] count;

    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       use_a;
    logic       use_b;
    logic [4:0] dx_rd;
    logic       lu_hit;
    logic       unused_fd_bits;

    // Which register fields the F/D instruction actually reads.
    always_comb begin
        src_a = bus.fd_insn[21:17];
        src_b = bus.fd_insn[16:12];
        use_a = 1'b0;
        use_b = 1'b0;
        unique case (bus.fd_insn[31:27])
            OP_ALU: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                use_a = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a = bus.fd_insn[26:22];
                src_b = bus.fd_insn[21:17];
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_JR: begin
                src_a = bus.fd_insn[26:22];
                use_a = 1'b1;
            end
            default: begin
                use_a = 1'b0;
                use_b = 1'b0;
            end
        endcase
    end

    // HOLD with hold_ext already low is the release cycle and re-checks the hazard as RUN does.
    assign dx_rd  = dx_insn[26:22];
    assign lu_hit = (state != BUBBLE) && (dx_insn[31:27] == OP_LW) && (dx_rd != 5'd0) &&
                    ((use_a && (src_a == dx_rd)) || (use_b && (src_b == dx_rd)));

    assign unused_fd_bits = ^bus.fd_insn[11:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            dx_insn <= NOP_INSN;
            dx_pc   <= 32'h0;
            bubble  <= 1'b0;
            count   <= '0;
        end else if (bus.hold_ext) begin
            state <= HOLD;
        end else if (bus.flush) begin
            state   <= RUN;
            dx_insn <= NOP_INSN;
            dx_pc   <= bus.fd_pc;
            bubble  <= 1'b1;
        end else if (lu_hit) begin
            state   <= BUBBLE;
            dx_insn <= NOP_INSN;
            bubble  <= 1'b1;
            if (count != '1) begin
                count <= count + 1'b1;
            end
        end else begin
            state   <= RUN;
            dx_insn <= bus.fd_insn;
            dx_pc   <= bus.fd_pc;
            bubble  <= 1'b0;
        end
    end

    assign bus.stall_fd    = !reset && (bus.hold_ext || (!bus.flush && lu_hit));
    assign bus.dx_insn_q   = dx_insn;
    assign bus.dx_pc_q     = dx_pc;
    assign bus.bubble_q    = bubble;
    assign bus.stall_count = count;
endmodule
